// File: rtl/instruction_prefetcher_pkg.sv
// Shared definitions for the instruction prefetcher: FSM state encoding,
// reset values of the code segment / instruction pointer and the
// segment:offset to physical address mapping.
package instruction_prefetcher_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_PUSH_LO = 3'd2;
   localparam logic [2:0] S_PUSH_HI = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = S_IDLE,
      ST_FETCH   = S_FETCH,
      ST_PUSH_LO = S_PUSH_LO,
      ST_PUSH_HI = S_PUSH_HI,
      ST_DRAIN   = S_DRAIN
   } prefetch_state_e;

   localparam logic [15:0] RESET_CS = 16'hFFFF;
   localparam logic [15:0] RESET_IP = 16'h0000;

   // Real-mode style translation; the carry out of bit 19 is dropped.
   function automatic logic [19:0] seg_to_phys(input logic [15:0] cs, input logic [15:0] ip);
      return {cs, 4'h0} + {4'h0, ip};
   endfunction

   localparam logic [19:0] RESET_PHYS = seg_to_phys(RESET_CS, RESET_IP);

endpackage

// File: rtl/prefetch_addr_gen.sv
// Physical fetch address generator: cs:ip -> 20-bit physical byte address.
module prefetch_addr_gen
   import instruction_prefetcher_pkg::*;
(
   input  logic [15:0] cs,
   input  logic [15:0] ip,
   output logic [19:0] phys_addr
);

   assign phys_addr = seg_to_phys(cs, ip);

endmodule

// File: rtl/instruction_prefetcher.sv
// Instruction prefetcher: reads 16-bit words at cs:ip and pushes the
// instruction bytes into a byte FIFO, one byte per cycle at best.
// Optional feature: define PREFETCH_STALL_COUNT_EN to add the 16-bit
// stall_cycles output counting memory wait cycles.
module instruction_prefetcher
   import instruction_prefetcher_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_new_ip,
   input  logic [15:0] new_cs,
   input  logic [15:0] new_ip,
   output logic        mem_access,
   input  logic        mem_ack,
   output logic [18:0] mem_address,
   input  logic [15:0] mem_data,
   output logic        fifo_wr_en,
   output logic [7:0]  fifo_wr_data,
   input  logic        fifo_full,
   output logic        fifo_reset
`ifdef PREFETCH_STALL_COUNT_EN
   ,
   output logic [15:0] stall_cycles
`endif
);

   prefetch_state_e state_reg, state_next;
   logic [15:0] cs_reg, ip_reg;
   logic [15:0] data_reg;
   logic [18:0] addr_reg;
   logic        fifo_reset_reg;
   logic [19:0] phys_addr;
   logic [7:0]  lane [2];

   prefetch_addr_gen u_addr_gen (
      .cs        (cs_reg),
      .ip        (ip_reg),
      .phys_addr (phys_addr)
   );

   // Byte lanes of the latched little-endian word.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign lane[gi] = data_reg[8*gi +: 8];
      end
   endgenerate

   assign mem_access   = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
   assign mem_address  = addr_reg;
   assign fifo_reset   = fifo_reset_reg;
   assign fifo_wr_data = (state_reg == ST_PUSH_HI) ? lane[1] : lane[0];
   // A redirect (this cycle or the flush cycle after it) never lets a stale byte through.
   assign fifo_wr_en   = ((state_reg == ST_PUSH_LO) || (state_reg == ST_PUSH_HI)) &&
                         !fifo_full && !load_new_ip && !fifo_reset_reg && !reset;

   // Next-state logic; a redirect wins over normal sequencing, but an
   // outstanding read must be drained before the bus is released.
   always_comb begin
      state_next = state_reg;
      if (load_new_ip) begin
         case (state_reg)
            ST_FETCH, ST_DRAIN: state_next = mem_ack ? ST_IDLE : ST_DRAIN;
            default:            state_next = ST_IDLE;
         endcase
      end else begin
         case (state_reg)
            ST_IDLE:    if (!fifo_full) state_next = ST_FETCH;
            ST_FETCH:   if (mem_ack) state_next = phys_addr[0] ? ST_PUSH_HI : ST_PUSH_LO;
            ST_PUSH_LO: if (!fifo_full) state_next = ST_PUSH_HI;
            ST_PUSH_HI: if (!fifo_full) state_next = ST_IDLE;
            ST_DRAIN:   if (mem_ack) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
         endcase
      end
   end

   // State, flush pulse and the word address frozen for the whole access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         fifo_reset_reg <= 1'b0;
         addr_reg       <= RESET_PHYS[19:1];
      end else begin
         state_reg      <= state_next;
         fifo_reset_reg <= load_new_ip;
         if ((state_reg == ST_IDLE) && (state_next == ST_FETCH))
            addr_reg <= phys_addr[19:1];
      end
   end

   // Fetch pointer and read data; each pushed byte advances ip, wrapping within the segment.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_reg   <= RESET_CS;
         ip_reg   <= RESET_IP;
         data_reg <= 16'h0000;
      end else if (load_new_ip) begin
         cs_reg   <= new_cs;
         ip_reg   <= new_ip;
         data_reg <= 16'h0000;
      end else begin
         if (fifo_wr_en)
            ip_reg <= ip_reg + 16'd1;
         if ((state_reg == ST_FETCH) && mem_ack)
            data_reg <= mem_data;
      end
   end

`ifdef PREFETCH_STALL_COUNT_EN
   logic [15:0] stall_reg;

   // Saturating count of cycles spent waiting on the memory.
   always_ff @(posedge clk) begin
      if (reset || load_new_ip)
         stall_reg <= 16'h0000;
      else if (mem_access && !mem_ack && (stall_reg != 16'hFFFF))
         stall_reg <= stall_reg + 16'd1;
   end

   assign stall_cycles = stall_reg;
`endif

endmodule

// File: doc/instruction_prefetcher.md
INSTRUCTION_PREFETCHER -- requirements
Module: instruction_prefetcher

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 load_new_ip  input  1  one-cycle pulse; flush and redirect fetch.
REQ-005 new_cs  input  16  code segment loaded on load_new_ip.
REQ-006 new_ip  input  16  instruction pointer loaded on load_new_ip.
REQ-007 mem_access  output  1  memory word read request.
REQ-008 mem_ack  input  1  one-cycle read completion; mem_data valid that cycle.
REQ-009 mem_address  output  19  physical word address, bits [19:1].
REQ-010 mem_data  input  16  little-endian read word.
REQ-011 fifo_wr_en  output  1  push fifo_wr_data into instruction byte FIFO.
REQ-012 fifo_wr_data  output  8  instruction byte.
REQ-013 fifo_full  input  1  FIFO cannot accept a byte this cycle.
REQ-014 fifo_reset  output  1  one-cycle FIFO flush.

Function
REQ-015 Physical fetch address SHALL be (cs << 4) + ip, 20 bits, carry out of bit 19 discarded.
REQ-016 States SHALL be IDLE, FETCH, PUSH_LO, PUSH_HI, DRAIN.
REQ-017 IDLE -> FETCH when fifo_full low and load_new_ip low; mem_access rises the following cycle.
REQ-018 In FETCH, mem_access and mem_address SHALL stay constant until the cycle mem_ack is high; mem_access drops the next cycle.
REQ-019 On mem_ack, mem_data SHALL be latched; -> PUSH_LO if ip[0]==0, else PUSH_HI.
REQ-020 PUSH_LO pushes latched [7:0], PUSH_HI pushes [15:8]; fifo_wr_en asserted only when fifo_full low; state held while fifo_full high.
REQ-021 Each pushed byte SHALL increment ip by 1, wrapping 0xFFFF -> 0x0000 with cs unchanged.
REQ-022 PUSH_LO -> PUSH_HI; PUSH_HI -> IDLE.
REQ-023 Best case SHALL be one byte per cycle; mem_ack to first fifo_wr_en latency exactly 1 cycle.
REQ-024 load_new_ip in any state SHALL load cs/ip, assert fifo_reset the next cycle, suppress fifo_wr_en that cycle and discard latched data.
REQ-025 load_new_ip during FETCH before mem_ack SHALL go to DRAIN: mem_access held until mem_ack, data discarded, then IDLE with new address.
REQ-026 load_new_ip in the same cycle as mem_ack SHALL discard that data, -> IDLE.
REQ-027 Repeated load_new_ip in DRAIN SHALL keep only the latest cs/ip.
REQ-028 Reads SHALL be issued only in FETCH or DRAIN.

Reset
REQ-029 reset SHALL force cs=0xFFFF, ip=0x0000, state IDLE, and drive mem_access, fifo_wr_en, fifo_reset to 0.
REQ-030 Reset mid-FETCH SHALL abandon the access; a late mem_ack after reset is ignored in IDLE.
REQ-031 First fetch after reset SHALL target physical 0xFFFF0 (mem_address 0x7FFF8).

Configuration
REQ-032 With PREFETCH_STALL_COUNT_EN defined, output stall_cycles (16 bits) SHALL count cycles with mem_access high and mem_ack low, saturating at 0xFFFF, cleared by reset or load_new_ip.
REQ-033 Without PREFETCH_STALL_COUNT_EN, the port and counter SHALL not exist.

Structure
REQ-034 Shared package SHALL hold the state enum and reset constants RESET_CS=16'hFFFF, RESET_IP=16'h0000.
REQ-035 Physical address generation SHALL be a sub-module prefetch_addr_gen (cs, ip -> 20-bit address).

Verification
REQ-036 Reset, memory returns 0x1234 at 0x7FFF8 -> mem_address 0x7FFF8; bytes 0x34,0x12 pushed on consecutive cycles; ip=0x0002.
REQ-037 load_new_ip cs=0x0000 ip=0x0101, data 0xBBAA -> only 0xBB pushed; ip=0x0102; next mem_address 0x00081.
REQ-038 fifo_full high 3 cycles in PUSH_LO -> no write while full; 0x34 then 0x12 resume; no byte lost or duplicated.
REQ-039 load_new_ip 2 cycles before mem_ack -> fifo_reset one cycle; acked data never pushed; next read from new address.
REQ-040 cs=0x1000 ip=0xFFFF -> one byte pushed from word 0x0FFFF's high byte; ip wraps 0x0000; next address 0x10000.
REQ-041 PREFETCH_STALL_COUNT_EN, mem_ack 5 cycles after mem_access -> stall_cycles=5; load_new_ip -> 0.
